mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port 64KB data/instruction memory among three requesters:
//  instruction fetch (if_), load/store unit (d_) and debug port (dbg_).
//  It sits between the core/debug logic and the memory block.
//  Per requester it provides a req/ack handshake and a read-data valid strobe.
//  It drives the memory's address/write/wrdata/wrbits inputs from registers.
// PARAMETERS
//  BASE_HI   16'h1000  address[31:16] value that selects the 64KB memory window
//  RR_CPU    1         1: round-robin if_/d_; 0: d_ always beats if_
// PORTS
//  clock        in   1   system clock, all state on rising edge
//  reset        in   1   synchronous, active-high
//  if_req       in   1   fetch request (read only)
//  if_addr      in   32  fetch byte address
//  if_ack       out  1   1-cycle pulse: fetch request accepted
//  if_rvalid    out  1   1-cycle pulse: rdata holds fetch result
//  d_req        in   1   load/store request
//  d_write      in   1   1=store, 0=load
//  d_addr       in   32  load/store byte address
//  d_wrdata     in   32  store data
//  d_wrbits     in   4   store byte enables
//  d_ack        out  1   1-cycle pulse: load/store accepted
//  d_rvalid     out  1   1-cycle pulse: rdata holds load result
//  dbg_req      in   1   debug request
//  dbg_write    in   1   1=debug write (all 4 bytes), 0=debug read
//  dbg_addr     in   32  debug byte address
//  dbg_in       in   32  debug write data
//  dbg_ack      out  1   1-cycle pulse: debug request accepted
//  dbg_rvalid   out  1   1-cycle pulse: rdata holds debug read result
//  rdata        out  32  shared read-data bus, meaningful only with an rvalid
//  addr_err     out  1   1-cycle pulse in RESP: granted address outside window
//  mem_address  out  32  to memory address (registered)
//  mem_read     out  1   to memory read enable (registered)
//  mem_write    out  1   to memory write enable (registered)
//  mem_wrdata   out  32  to memory write data (registered)
//  mem_wrbits   out  4   to memory byte mask (registered)
//  mem_rddata   in   32  from memory read data, valid the cycle after address
// BEHAVIOUR
//  - Reset: state=IDLE, every output 0, round-robin pointer favours d_.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE; one access per 3 cycles max.
//  - IDLE: if any req, pick winner; at edge latch winner's cmd into mem_*,
//    set winner's ack=1 and enter ACCESS. No req: stay IDLE, mem_* =0.
//  - Priority: dbg > CPU. Between if_/d_: RR_CPU=1 -> alternate, pointer flips
//    only when both CPU reqs were pending at grant; RR_CPU=0 -> d_ > if_.
//  - ACCESS: ack high this cycle only; mem_* held; memory samples at edge.
//  - RESP: mem_* forced 0 (read/write deasserted). rdata=mem_rddata. For a read
//    the winner's rvalid=1. For a write no rvalid. Next state IDLE.
//  - Debug writes drive mem_wrbits=4'b1111; fetch/load use mem_wrbits=0.
//  - Out-of-window (addr[31:16]!=BASE_HI): mem_write forced 0 at latch, access
//    still completes all 3 states; rdata=0 in RESP; addr_err=1 in RESP.
//  - Requester must hold req and cmd until its ack; must drop req by the cycle
//    after ack unless another access is wanted; req still high in IDLE = new access.
//  - Requests arriving in ACCESS/RESP are ignored until IDLE; no queuing.
//  - Reset mid-operation: next edge -> IDLE, all outputs 0; a write already
//    sampled by memory stays committed; no ack/rvalid for the aborted access.
// TESTING
//  - if_req=1 addr 0x1000_0010, mem holds 0xDEADBEEF -> if_ack cyc1, if_rvalid +
//    rdata=0xDEADBEEF cyc2, IDLE cyc3.
//  - d_ store 0x1000_0020 data 0x11223344 wrbits 4'b0011, then load -> mem
//    write once, mem_wrbits=0011; load returns 0xXXXX3344 per prior content.
//  - if_req, d_req, dbg_req same cycle -> dbg granted first; RR_CPU=1: d_ then
//    if_; RR_CPU=0: d_ before if_.
//  - if_/d_ held high continuously, RR_CPU=1 -> acks alternate d,if,d,if, 3 cyc apart.
//  - d_ store addr 0x2000_0000 -> mem_write never 1, addr_err pulse in RESP, d_ack.
//  - reset asserted during ACCESS -> next cycle all outputs 0, no rvalid, IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes, shared read data and memory command bus
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_rvalid;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wrdata;
  logic [3:0]  d_wrbits;
  logic        d_ack;
  logic        d_rvalid;
  logic        dbg_req;
  logic        dbg_write;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_in;
  logic        dbg_ack;
  logic        dbg_rvalid;
  logic [31:0] rdata;
  logic        addr_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wrdata;
  logic [3:0]  mem_wrbits;
  logic [31:0] mem_rddata;
  modport slave (
    input  if_req, if_addr, d_req, d_write, d_addr, d_wrdata, d_wrbits,
           dbg_req, dbg_write, dbg_addr, dbg_in, mem_rddata,
    output if_ack, if_rvalid, d_ack, d_rvalid, dbg_ack, dbg_rvalid, rdata, addr_err,
           mem_address, mem_read, mem_write, mem_wrdata, mem_wrbits
  );
  modport master (
    output if_req, if_addr, d_req, d_write, d_addr, d_wrdata, d_wrbits,
           dbg_req, dbg_write, dbg_addr, dbg_in, mem_rddata,
    input  if_ack, if_rvalid, d_ack, d_rvalid, dbg_ack, dbg_rvalid, rdata, addr_err,
           mem_address, mem_read, mem_write, mem_wrdata, mem_wrbits
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 64KB memory between fetch, load/store and debug
module mem_arbiter #(
  parameter logic [15:0] BASE_HI = 16'h1000,
  parameter bit          RR_CPU  = 1'b1
) (
  input logic         clock,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [1:0] W_IF = 2'd0, W_D = 2'd1, W_DBG = 2'd2;
  state_t      state_q, state_d;
  logic [1:0]  win_q, win_d, grant;
  logic        rr_q, rr_d, rd_q, rd_d, err_q, err_d;
  logic        read_q, read_d, write_q, write_d;
  logic [31:0] addr_q, addr_d, wrdata_q, wrdata_d;
  logic [3:0]  wrbits_q, wrbits_d;
  logic        any_req, both_cpu, g_write, g_err;
  logic [31:0] g_addr, g_data;
  logic [3:0]  g_bits;
  // Pick this cycle's winner (debug first, rr_q=1 favours d_) and mux its command
  always_comb begin
    any_req  = bus.if_req | bus.d_req | bus.dbg_req;
    both_cpu = bus.if_req & bus.d_req;
    grant    = bus.dbg_req ? W_DBG : both_cpu ? ((!RR_CPU || rr_q) ? W_D : W_IF) : bus.d_req ? W_D : W_IF;
    g_write  = (grant == W_DBG) ? bus.dbg_write : (grant == W_D) ? bus.d_write : 1'b0;
    g_addr   = (grant == W_DBG) ? bus.dbg_addr : (grant == W_D) ? bus.d_addr : bus.if_addr;
    g_data   = (grant == W_DBG) ? bus.dbg_in : (grant == W_D) ? bus.d_wrdata : 32'h0;
    g_bits   = !g_write ? 4'h0 : (grant == W_DBG) ? 4'hf : bus.d_wrbits;
    g_err    = g_addr[31:16] != BASE_HI;
  end
  // IDLE latches the winner's command, ACCESS holds it for the memory edge, RESP returns data
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_d     = rr_q;
    rd_d     = rd_q;
    err_d    = err_q;
    read_d   = read_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wrbits_d = wrbits_q;
    if (state_q == ACCESS) begin
      state_d  = RESP;
      read_d   = 1'b0;
      write_d  = 1'b0;
      addr_d   = '0;
      wrdata_d = '0;
      wrbits_d = '0;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end else if (any_req) begin
      state_d  = ACCESS;
      win_d    = grant;
      rd_d     = !g_write;
      err_d    = g_err;
      read_d   = !g_write;
      write_d  = g_write & !g_err;
      addr_d   = g_addr;
      wrdata_d = g_data;
      wrbits_d = g_bits;
      rr_d     = (both_cpu && !bus.dbg_req) ? !rr_q : rr_q;
    end
  end
  // State and registered memory command
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= W_IF;
      rr_q     <= 1'b1;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
      wrbits_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_q     <= rr_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      read_q   <= read_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wrbits_q <= wrbits_d;
    end
  end
  assign bus.if_ack      = state_q == ACCESS && win_q == W_IF;
  assign bus.d_ack       = state_q == ACCESS && win_q == W_D;
  assign bus.dbg_ack     = state_q == ACCESS && win_q == W_DBG;
  assign bus.if_rvalid   = state_q == RESP && rd_q && win_q == W_IF;
  assign bus.d_rvalid    = state_q == RESP && rd_q && win_q == W_D;
  assign bus.dbg_rvalid  = state_q == RESP && rd_q && win_q == W_DBG;
  assign bus.rdata       = (state_q == RESP && !err_q) ? bus.mem_rddata : 32'h0;
  assign bus.addr_err    = state_q == RESP && err_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_read    = read_q;
  assign bus.mem_write   = write_q;
  assign bus.mem_wrdata  = wrdata_q;
  assign bus.mem_wrbits  = wrbits_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for the three-way memory arbiter
module tb_mem_arbiter;
  localparam logic [15:0] BASE = 16'h1000;
  localparam bit          RR   = 1'b1;
  typedef struct {logic v; logic wr; logic [31:0] addr; logic [31:0] data; logic [3:0] bits;} txn_t;
  typedef struct {int kind; int who; logic [31:0] data; int cyc;} exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  mem_arbiter_if bus();
  mem_arbiter #(.BASE_HI(BASE), .RR_CPU(RR)) dut (.clock(clock), .reset(reset), .bus(bus));

  logic [31:0] mem [16384];
  logic [31:0] mm [16384];
  txn_t pend [3];
  int   done_at [3];
  exp_t expq [$];
  int   ack_who [$];
  int   ack_cyc [$];
  int   cyc = 0, free_at = 0, checks = 0, errors = 0, wr_cnt = 0, last_contest = 0;
  logic [3:0] last_bits = 4'h0;
  bit   rnd_mode = 0, cont = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (bus.mem_read) bus.mem_rddata <= mem[bus.mem_address[15:2]];
    if (bus.mem_write)
      for (int b = 0; b < 4; b++)
        if (bus.mem_wrbits[b]) mem[bus.mem_address[15:2]][8*b +: 8] <= bus.mem_wrdata[8*b +: 8];
  end

  function automatic string kname(int k);
    return (k == 0) ? "ack" : (k == 1) ? "rvalid" : "addr_err";
  endfunction

  function automatic bit all_zero();
    return !(bus.if_ack | bus.d_ack | bus.dbg_ack | bus.if_rvalid | bus.d_rvalid | bus.dbg_rvalid |
             bus.addr_err | bus.mem_read | bus.mem_write) && bus.rdata == 32'h0 &&
           bus.mem_address == 32'h0 && bus.mem_wrdata == 32'h0 && bus.mem_wrbits == 4'h0;
  endfunction

  function automatic txn_t rand_txn(int w);
    txn_t t;
    t.v    = 1'b1;
    t.wr   = (w == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    t.addr = {($urandom_range(0, 9) == 0) ? 16'h2000 : BASE, 10'd0, 4'($urandom_range(0, 15)), 2'b00};
    t.data = $urandom;
    t.bits = (w == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    return t;
  endfunction

  task automatic drive();
    bus.if_req    = pend[0].v;
    bus.if_addr   = pend[0].addr;
    bus.d_req     = pend[1].v;
    bus.d_write   = pend[1].wr;
    bus.d_addr    = pend[1].addr;
    bus.d_wrdata  = pend[1].data;
    bus.d_wrbits  = pend[1].bits;
    bus.dbg_req   = pend[2].v;
    bus.dbg_write = pend[2].wr;
    bus.dbg_addr  = pend[2].addr;
    bus.dbg_in    = pend[2].data;
  endtask

  // Reference: one access per 3-cycle slot; debug first, contested CPU slots go to whoever lost the last contest
  task automatic model_step();
    int w;
    txn_t t;
    logic [3:0] bm;
    logic e;
    if (cyc < free_at || !(pend[0].v || pend[1].v || pend[2].v)) return;
    if (pend[2].v) w = 2;
    else if (pend[0].v && pend[1].v) begin
      w = (!RR || last_contest == 0) ? 1 : 0;
      last_contest = w;
    end else w = pend[1].v ? 1 : 0;
    t = pend[w];
    e = t.addr[31:16] != BASE;
    expq.push_back('{0, w, 32'h0, cyc + 1});
    if (!t.wr) expq.push_back('{1, w, e ? 32'h0 : mm[t.addr[15:2]], cyc + 2});
    else if (!e) begin
      bm = (w == 2) ? 4'hf : t.bits;
      for (int b = 0; b < 4; b++) if (bm[b]) mm[t.addr[15:2]][8*b +: 8] = t.data[8*b +: 8];
    end
    if (e) expq.push_back('{2, 0, 32'h0, cyc + 2});
    free_at    = cyc + 3;
    done_at[w] = cyc + 2;
  endtask

  task automatic tick();
    @(negedge clock);
    for (int w = 0; w < 3; w++)
      if (pend[w].v && done_at[w] >= 0 && cyc >= done_at[w]) begin
        pend[w].v  = 1'b0;
        done_at[w] = -1;
      end
    if (rnd_mode) for (int w = 0; w < 3; w++) if (!pend[w].v && $urandom_range(0, 2) == 0) pend[w] = rand_txn(w);
    if (cont) for (int w = 0; w < 2; w++) if (!pend[w].v) pend[w] = '{1'b1, 1'b0, 32'h1000_0040 | 32'(w * 4), 32'h0, 4'h0};
    drive();
    model_step();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80; i++) begin
      if (!(pend[0].v || pend[1].v || pend[2].v) && expq.size() == 0) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout pending_expect=%0d required=0", expq.size());
  endtask

  // Monitor: every ack/rvalid/addr_err the DUT shows is matched against the scoreboard
  always @(negedge clock) begin : mon
    exp_t obs [$];
    exp_t e;
    bit hit;
    logic [2:0] a, r;
    a = {bus.dbg_ack, bus.d_ack, bus.if_ack};
    r = {bus.dbg_rvalid, bus.d_rvalid, bus.if_rvalid};
    obs.delete();
    for (int w = 0; w < 3; w++) begin
      if (a[w]) begin
        obs.push_back('{0, w, 32'h0, cyc});
        ack_who.push_back(w);
        ack_cyc.push_back(cyc);
      end
      if (r[w]) obs.push_back('{1, w, bus.rdata, cyc});
    end
    if (bus.addr_err) obs.push_back('{2, 0, 32'h0, cyc});
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      e = expq.pop_front();
      hit = 0;
      checks++;
      for (int i = 0; i < obs.size(); i++)
        if (!hit && obs[i].kind == e.kind && obs[i].who == e.who) begin
          hit = 1;
          if (obs[i].data !== e.data) begin
            errors++;
            $display("FAIL %s_data who=%0d cyc=%0d got=%h required=%h", kname(e.kind), e.who, cyc, obs[i].data, e.data);
          end
          obs.delete(i);
        end
      if (!hit) begin
        errors++;
        $display("FAIL %s_missing who=%0d cyc=%0d got=none required_cyc=%0d", kname(e.kind), e.who, cyc, e.cyc);
      end
    end
    foreach (obs[i]) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected who=%0d cyc=%0d got=1 required=0", kname(obs[i].kind), obs[i].who, cyc);
    end
    if (bus.mem_write) begin
      checks++;
      wr_cnt++;
      last_bits = bus.mem_wrbits;
      if (bus.mem_address[31:16] != BASE) begin
        errors++;
        $display("FAIL write_window addr=%h got=mem_write1 required=0", bus.mem_address);
      end
    end
  end

  initial begin
    int w0, got;
    bit ok;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = 32'(i) * 32'h9E37_79B9;
      mm[i]  = mem[i];
    end
    mem[4] = 32'hDEAD_BEEF;
    mm[4]  = 32'hDEAD_BEEF;
    bus.mem_rddata = 32'h0;
    for (int w = 0; w < 3; w++) begin
      pend[w]    = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
      done_at[w] = -1;
    end
    drive();
    repeat (3) @(negedge clock);
    checks++;
    if (!all_zero()) begin
      errors++;
      $display("FAIL reset_outputs got=nonzero required=all_zero");
    end
    reset = 1'b0;
    pend[0] = '{1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'h0};
    wait_drain();
    pend[1] = '{1'b1, 1'b1, 32'h1000_0020, 32'h1122_3344, 4'b0011};
    w0 = wr_cnt;
    wait_drain();
    checks++;
    if (wr_cnt - w0 != 1 || last_bits != 4'b0011) begin
      errors++;
      $display("FAIL store_once writes=%0d bits=%b required writes=1 bits=0011", wr_cnt - w0, last_bits);
    end
    pend[1] = '{1'b1, 1'b0, 32'h1000_0020, 32'h0, 4'h0};
    wait_drain();
    ack_who.delete();
    pend[0] = '{1'b1, 1'b0, 32'h1000_0030, 32'h0, 4'h0};
    pend[1] = '{1'b1, 1'b0, 32'h1000_0034, 32'h0, 4'h0};
    pend[2] = '{1'b1, 1'b0, 32'h1000_0038, 32'h0, 4'h0};
    wait_drain();
    got = 0;
    foreach (ack_who[i]) got = got * 10 + ack_who[i] + 1;
    checks++;
    if (got != 321) begin
      errors++;
      $display("FAIL grant_order got=%0d required=321 (dbg,d,if)", got);
    end
    ack_who.delete();
    ack_cyc.delete();
    cont = 1;
    repeat (24) tick();
    cont = 0;
    wait_drain();
    ok = ack_who.size() >= 6;
    for (int i = 1; i < ack_who.size(); i++)
      if (ack_who[i] == ack_who[i-1] || ack_cyc[i] - ack_cyc[i-1] != 3) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_alternate acks=%0d got=not_alternating_3cyc required=alternating_3cyc", ack_who.size());
    end
    pend[1] = '{1'b1, 1'b1, 32'h2000_0000, 32'hCAFE_F00D, 4'hf};
    w0 = wr_cnt;
    wait_drain();
    checks++;
    if (wr_cnt != w0) begin
      errors++;
      $display("FAIL out_of_window_write got=%0d required=0", wr_cnt - w0);
    end
    pend[1] = '{1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'h0};
    wait_drain();
    pend[2] = '{1'b1, 1'b1, 32'h1000_0008, 32'h0BAD_C0DE, 4'h0};
    wait_drain();
    pend[2] = '{1'b1, 1'b0, 32'h1000_0008, 32'h0, 4'h0};
    wait_drain();
    rnd_mode = 1;
    repeat (600) tick();
    rnd_mode = 0;
    wait_drain();
    pend[1] = '{1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'h0};
    tick();
    if (expq.size() > 0 && expq[expq.size()-1].kind == 1) void'(expq.pop_back());
    tick();
    reset = 1'b1;
    pend[1].v  = 1'b0;
    done_at[1] = -1;
    drive();
    @(negedge clock);
    checks++;
    if (!all_zero()) begin
      errors++;
      $display("FAIL reset_mid_access got=nonzero required=all_zero");
    end
    reset = 1'b0;
    last_contest = 0;
    free_at = cyc;
    ack_who.delete();
    pend[0] = '{1'b1, 1'b0, 32'h1000_0044, 32'h0, 4'h0};
    pend[1] = '{1'b1, 1'b0, 32'h1000_0048, 32'h0, 4'h0};
    wait_drain();
    checks++;
    if (ack_who.size() == 0 || ack_who[0] != 1) begin
      errors++;
      $display("FAIL rr_after_reset got=%0d required=1", (ack_who.size() == 0) ? -1 : ack_who[0]);
    end
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
